// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions used by the restore sequencer.
package ooo_pkg;

    // Architectural register count, which is also the number of rename map-table lines.
    localparam int NUM_ARCH_REGS = 32;

    // Recovery sequencer states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        FLUSH    = 3'd2,
        MAPCLR   = 3'd3,
        REDIRECT = 3'd4
    } restore_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating enable counter. It holds at all ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: advance when enabled, unless the counter is already saturated.
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/restore_sequencer.sv
// Multi-cycle recovery controller for mispredictions and LSQ violations.
// The sequence is: drain the in-flight committed store, flush the ROB, LSQ and
// reservation stations, clear the rename map in groups, then redirect fetch.
// Defining RESTORE_STATS_EN adds the restore_count_o and recover_cycles_o counters.
// The recovery sequence is the same whether or not that macro is defined.
// Valid/ready semantics: fetch_redirect_o is a valid that stays high, with
// fetch_pc_o stable, until fetch_ack_i is sampled high on a rising edge.
// state_o exposes the FSM state for debug.
module restore_sequencer
    import ooo_pkg::*;
#(
    parameter int NUM_ARCH_REGS = ooo_pkg::NUM_ARCH_REGS,
    parameter int CLR_PER_CYCLE = 8,
    parameter int DRAIN_TIMEOUT = 15,
    parameter int PC_W          = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     restore_req_i,
    input  logic [PC_W-1:0]          restore_pc_i,
    input  logic                     store_pending_i,
    input  logic                     fetch_ack_i,
    output logic                     commit_stall_o,
    output logic                     rob_flush_o,
    output logic                     lsq_flush_o,
    output logic                     rs_flush_o,
    output logic [NUM_ARCH_REGS-1:0] map_clear_o,
    output logic                     fetch_redirect_o,
    output logic [PC_W-1:0]          fetch_pc_o,
    output logic                     busy_o,
    output logic                     drain_timeout_o,
    output logic [2:0]               state_o
`ifdef RESTORE_STATS_EN
    ,
    output logic [31:0]              restore_count_o,
    output logic [31:0]              recover_cycles_o
`endif
);

    localparam int NUM_GROUPS = NUM_ARCH_REGS / CLR_PER_CYCLE;
    localparam int IDX_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int TMR_W      = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_GROUPS - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(DRAIN_TIMEOUT);

    restore_state_e   state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             timeout_q, timeout_d;

    // State register and datapath flops. Reset aborts any sequence in progress.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            pc_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            pc_q      <= pc_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic, plus the timer, group index, PC latch and sticky timeout.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        pc_d      = pc_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (restore_req_i) begin
                    pc_d    = restore_pc_i;
                    timer_d = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!store_pending_i) begin
                    state_d = FLUSH;
                end else begin
                    timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
                    // A store that never retires must not stall recovery forever.
                    if (timer_d == TMR_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = FLUSH;
                    end
                end
            end
            FLUSH: begin
                idx_d   = '0;
                state_d = MAPCLR;
            end
            MAPCLR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (fetch_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are Moore decodes of the state, except commit_stall_o.
    // commit_stall_o also covers the request cycle, so younger instructions never commit.
    always_comb begin
        busy_o           = (state_q != IDLE);
        commit_stall_o   = restore_req_i | busy_o;
        rob_flush_o      = (state_q == FLUSH);
        lsq_flush_o      = (state_q == FLUSH);
        rs_flush_o       = (state_q == FLUSH);
        fetch_redirect_o = (state_q == REDIRECT);
        fetch_pc_o       = pc_q;
        drain_timeout_o  = timeout_q;
        state_o          = state_q;
        map_clear_o      = '0;
        if (state_q == MAPCLR) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                if (idx_q == IDX_W'(g)) begin
                    map_clear_o[g*CLR_PER_CYCLE +: CLR_PER_CYCLE] = '1;
                end
            end
        end
    end

    // A new request while a recovery is in progress is dropped; in simulation it is an error.
    a_no_req_while_busy: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(restore_req_i && busy_o));

`ifdef RESTORE_STATS_EN
    sat_counter #(.W(32)) u_restore_count (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      ((state_q == IDLE) && restore_req_i),
        .count_o   (restore_count_o)
    );

    sat_counter #(.W(32)) u_recover_cycles (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (busy_o),
        .count_o   (recover_cycles_o)
    );
`endif

endmodule

// File: tb/tb_restore_sequencer.sv
// Testbench for restore_sequencer. A per-cycle expected-output queue is filled
// from a phase-level model of a recovery. A negedge monitor pops the queue and compares.
module tb_restore_sequencer;

    localparam int REC_W = 103;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        restore_req = 1'b0;
    logic [63:0] restore_pc = '0;
    logic        store_pending = 1'b0;
    logic        fetch_ack = 1'b0;
    logic        commit_stall, rob_flush, lsq_flush, rs_flush;
    logic [31:0] map_clear;
    logic        fetch_redirect;
    logic [63:0] fetch_pc;
    logic        busy, drain_timeout;
    logic [2:0]  state;
`ifdef RESTORE_STATS_EN
    logic [31:0] restore_count, recover_cycles;
`endif

    // Clock generation.
    always #5 clk = ~clk;

    restore_sequencer dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .restore_req_i    (restore_req),
        .restore_pc_i     (restore_pc),
        .store_pending_i  (store_pending),
        .fetch_ack_i      (fetch_ack),
        .commit_stall_o   (commit_stall),
        .rob_flush_o      (rob_flush),
        .lsq_flush_o      (lsq_flush),
        .rs_flush_o       (rs_flush),
        .map_clear_o      (map_clear),
        .fetch_redirect_o (fetch_redirect),
        .fetch_pc_o       (fetch_pc),
        .busy_o           (busy),
        .drain_timeout_o  (drain_timeout),
        .state_o          (state)
`ifdef RESTORE_STATS_EN
        ,
        .restore_count_o  (restore_count),
        .recover_cycles_o (recover_cycles)
`endif
    );

    logic [REC_W-1:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] pc_m = '0;
    logic        to_m = 1'b0;
    int          n_txn = 0;
    int          busy_cycles = 0;

    function automatic logic [REC_W-1:0] pack(logic b, logic s, logic f, logic [31:0] m,
                                              logic r, logic [63:0] p, logic t);
        return {b, s, f, f, f, m, r, p, t};
    endfunction

    function automatic logic [REC_W-1:0] actual();
        return {busy, commit_stall, rob_flush, lsq_flush, rs_flush, map_clear,
                fetch_redirect, fetch_pc, drain_timeout};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every cycle that has a queued expectation.
    always @(negedge clk) begin
        logic [REC_W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (actual() !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t act=%h exp=%h", $time, actual(), e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles: no request, noise on the ignored inputs.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, pc_m, to_m));
            restore_req   = 1'b0;
            restore_pc    = {$urandom, $urandom};
            store_pending = 1'($urandom_range(0, 1));
            fetch_ack     = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    // One recovery. The store stays pending for the first k DRAIN cycles, and fetch acks
    // after a redirect cycles. With abort set, reset hits during map group 2.
    task automatic run_txn(input int k, input int a, input logic [63:0] pc, input bit abort);
        int d;
        int last;
        bit to;
        logic [31:0] m;
        d    = (k >= 15) ? 15 : k + 1;
        to   = (k >= 15);
        last = d + 6 + a;
        for (int c = 0; c <= last; c++) begin
            if (abort && c == d + 4) begin
                chk("mapclr_group2", map_clear, 32'h00FF_0000);
                reset_n = 1'b0;
                #1;
                chk("abort_outputs", actual(), '0);
                chk("abort_state", state, 3'd0);
                pc_m        = '0;
                to_m        = 1'b0;
                n_txn       = 0;
                busy_cycles = 0;
                restore_req   = 1'b0;
                store_pending = 1'b0;
                fetch_ack     = 1'b0;
                step();
                reset_n = 1'b1;
                return;
            end
            if (c == 0) n_txn++;
            if (c >= 1) busy_cycles++;
            if (c == 1) pc_m = pc;
            if (c == d + 1 && to) to_m = 1'b1;
            m = (c >= d + 2 && c <= d + 5) ? (32'hFF << (8 * (c - d - 2))) : 32'h0;
            exp_q.push_back(pack(c >= 1, 1'b1, c == d + 1, m, c >= d + 6, pc_m, to_m));
            restore_req   = (c == 0);
            restore_pc    = (c == 0) ? pc : {$urandom, $urandom};
            store_pending = (c >= 1 && c <= d) ? (c <= k) : 1'($urandom_range(0, 1));
            fetch_ack     = (c >= d + 6) ? (c == last) : 1'($urandom_range(0, 1));
            step();
        end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("reset_outputs", actual(), '0);
        chk("reset_state", state, 3'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        run_txn(0, 0, 64'h40, 1'b0);                  // minimum-latency recovery
        idle(2);
        run_txn(4, 0, 64'h1234_5678_9ABC_DEF0, 1'b0); // store drains late, FLUSH at c6
        idle(1);
        run_txn(14, 0, 64'h100, 1'b0);                // drains just before the timeout
        run_txn(20, 0, 64'h200, 1'b0);                // stuck store forces a timeout
        idle(2);
        run_txn(0, 10, 64'h300, 1'b0);                // fetch withholds ack for 10 cycles
        idle(1);
        run_txn(15, 0, 64'h400, 1'b0);                // hits the timeout exactly
        run_txn(0, 0, 64'h500, 1'b1);                 // reset during map group 2
        idle(2);
        run_txn(0, 0, 64'h600, 1'b0);                 // restart after reset
        run_txn(0, 1, 64'h700, 1'b0);                 // back-to-back recovery
        for (int i = 0; i < 30; i++) begin
            run_txn($urandom_range(0, 18), $urandom_range(0, 4),
                    {$urandom, $urandom}, 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(2);
        step();
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
`ifdef RESTORE_STATS_EN
        chk("restore_count", restore_count, 128'(n_txn));
        chk("recover_cycles", recover_cycles, 128'(busy_cycles));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog t=%0t act=running exp=finished", $time);
        $fatal(1);
    end

endmodule
